aes_key_loader: RTL

Parametrised key-ingest block that assembles a byte stream into a wide key register for AES-128, AES-192 or AES-256. It owns its own byte counter and length selection and uses a valid/ready input handshake. A key_valid/key_ack output handshake holds the key until the key-expansion stage consumes it. It sits between the byte-serial host interface and the key schedule.

---
 rtl/aes_key_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/aes_key_loader.sv
// aes_key_loader: assembles a byte-serial key stream (MSB-first) into a wide
// key register for AES-128/192/256, with a valid/ready byte input and a
// key_valid/key_ack output handshake towards the key schedule.
module aes_key_loader #(
    parameter int MAX_BYTES = 32,
    parameter int CNT_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             key_size,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [MAX_BYTES*8-1:0] key_out,
    output logic [1:0]             key_len,
    output logic                   key_valid,
    input  logic                   key_ack,
    output logic [CNT_W-1:0]       byte_cnt,
    output logic                   done,
    output logic                   cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    // Key length in bytes for a size code; the reserved code maps to 0.
    function automatic logic [CNT_W-1:0] size_len(input logic [1:0] s);
        case (s)
            2'b00:   size_len = CNT_W'(16);
            2'b01:   size_len = CNT_W'(24);
            2'b10:   size_len = CNT_W'(32);
            default: size_len = '0;
        endcase
    endfunction

    logic [CNT_W-1:0] cur_len;
    logic             size_ok;
    logic             last_byte;

    // Legality of the size on the start request, and final-byte detection.
    always_comb begin
        size_ok   = (key_size != 2'b11) && (size_len(key_size) <= CNT_W'(MAX_BYTES));
        cur_len   = size_len(key_len);
        last_byte = (byte_cnt == cur_len - CNT_W'(1));
    end

    // Control FSM with all outputs registered; start overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_out   <= '0;
            key_len   <= 2'b00;
            byte_cnt  <= '0;
            din_ready <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values; done/cfg_err default low to form pulses.
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (start) begin
                key_valid <= 1'b0;
                if (size_ok) begin
                    key_len   <= key_size;
                    key_out   <= '0;
                    byte_cnt  <= '0;
                    din_ready <= 1'b1;
                    state     <= LOAD;
                end else begin
                    cfg_err   <= 1'b1;
                    din_ready <= 1'b0;
                    state     <= IDLE;
                end
            end else begin
                case (state)
                    LOAD: begin
                        if (din_valid) begin
                            for (int i = 0; i < MAX_BYTES; i++) begin
                                if (byte_cnt == CNT_W'(i)) begin
                                    key_out[(MAX_BYTES-1-i)*8 +: 8] <= din;
                                end
                            end
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            if (last_byte) begin
                                state     <= HOLD;
                                din_ready <= 1'b0;
                                key_valid <= 1'b1;
                                done      <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (key_ack) begin
                            key_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
